// File: rtl/rf_read_stage_p.sv
// rf_read_stage_p: register-read stage holding the architectural register file,
// the flags register and a per-register counting scoreboard of in-flight writers.
// It stalls the translator on RAW hazards or a saturated counter, and latches
// decoded operands into the EXE pipeline latch with an explicit valid bit.
// Optional build macro RF_READ_FORWARD_EN: a read of a register (or the flags)
// whose only outstanding writer is being written back this cycle takes the
// writeback value directly instead of waiting one more cycle.
//
// Handshake: the translator asserts in_valid with a uop; the uop is consumed on
// a clock edge where in_valid=1, stall_out=0 and flush=0 (accept). While
// stall_out=1 the translator must hold the uop stable. out_valid marks a live
// uop in the EXE latch; mem_stall freezes the latch, flush empties it.
module rf_read_stage_p #(
    parameter int DATA_W = 16,
    parameter int ID_W   = 5,
    parameter int CNT_W  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [5:0]        in_opcode,
    input  logic [ID_W-1:0]   in_rd0_id,
    input  logic [ID_W-1:0]   in_rd1_id,
    input  logic [ID_W-1:0]   in_wr_id,
    input  logic [7:0]        in_fmask,
    input  logic              in_rd_flags,
    input  logic [15:0]       in_imm,
    input  logic [15:0]       in_npc,
    input  logic              in_eoi,
    input  logic              flush,
    input  logic              mem_stall,
    input  logic              wb_valid,
    input  logic [ID_W-1:0]   wb_id,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [7:0]        wb_fmask,
    input  logic [7:0]        wb_flags,
    output logic              stall_out,
    output logic              bubble,
    output logic              out_valid,
    output logic [5:0]        out_opcode,
    output logic [ID_W-1:0]   out_wr_id,
    output logic [7:0]        out_fmask,
    output logic [15:0]       out_imm,
    output logic [15:0]       out_npc,
    output logic              out_eoi,
    output logic [ID_W-1:0]   out_rd0_id,
    output logic [ID_W-1:0]   out_rd1_id,
    output logic [DATA_W-1:0] out_rd0_data,
    output logic [DATA_W-1:0] out_rd1_data,
    output logic [7:0]        out_flags
);

    localparam int NREGS = 2 ** ID_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] rf      [NREGS];
    logic [CNT_W-1:0]  cnt     [NREGS];
    logic [CNT_W-1:0]  cnt_nxt [NREGS];
    logic [7:0]        flags;
    logic [CNT_W-1:0]  fcnt;
    logic [CNT_W-1:0]  fcnt_nxt;

    logic              pend0, pend1, pendf, full, hazard, accept;
    logic              byp0, byp1, bypf;
    logic [DATA_W-1:0] rd0_data, rd1_data;
    logic [7:0]        flags_merged, flags_rd;

    // Saturating-at-zero counter update: +inc, -dec_a, -dec_b in one step.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                    input logic inc,
                                                    input logic dec_a,
                                                    input logic dec_b);
        logic [CNT_W+1:0] up;
        logic [CNT_W+1:0] down;
        logic [CNT_W+1:0] diff;
        up   = {2'b00, cur} + {{(CNT_W+1){1'b0}}, inc};
        down = {{(CNT_W+1){1'b0}}, dec_a} + {{(CNT_W+1){1'b0}}, dec_b};
        diff = up - down;
        if (up < down) return '0;
        return diff[CNT_W-1:0];
    endfunction

    assign flags_merged = (flags & ~wb_fmask) | (wb_flags & wb_fmask);

`ifdef RF_READ_FORWARD_EN
    assign byp0 = wb_valid && (wb_id == in_rd0_id) && (in_rd0_id != '0) && (cnt[in_rd0_id] == CNT_W'(1));
    assign byp1 = wb_valid && (wb_id == in_rd1_id) && (in_rd1_id != '0) && (cnt[in_rd1_id] == CNT_W'(1));
    assign bypf = wb_valid && (wb_fmask != 8'h00) && (fcnt == CNT_W'(1));
`else
    assign byp0 = 1'b0;
    assign byp1 = 1'b0;
    assign bypf = 1'b0;
`endif

    // Operand read, hazard detection and stall/accept decisions.
    always_comb begin
        pend0    = (cnt[in_rd0_id] != '0) && !byp0;
        pend1    = (cnt[in_rd1_id] != '0) && !byp1;
        pendf    = (fcnt != '0) && !bypf;
        full     = ((in_wr_id != '0) && (cnt[in_wr_id] == CNT_MAX)) ||
                   ((in_fmask != 8'h00) && (fcnt == CNT_MAX));
        hazard   = in_valid && (pend0 || pend1 || (in_rd_flags && pendf) || full);
        bubble   = hazard && !mem_stall;
        stall_out = hazard || mem_stall;
        accept   = in_valid && !stall_out && !flush;
        rd0_data = (in_rd0_id == '0) ? '0 : (byp0 ? wb_data : rf[in_rd0_id]);
        rd1_data = (in_rd1_id == '0) ? '0 : (byp1 ? wb_data : rf[in_rd1_id]);
        flags_rd = bypf ? flags_merged : flags;
    end

    // Next scoreboard counts: accepted writers add, writebacks and killed writers remove.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            cnt_nxt[i] = '0;
            if (i != 0) begin
                cnt_nxt[i] = next_count(cnt[i],
                                        accept && (in_wr_id == ID_W'(i)),
                                        wb_valid && (wb_id == ID_W'(i)),
                                        flush && out_valid && (out_wr_id == ID_W'(i)));
            end
        end
        fcnt_nxt = next_count(fcnt,
                              accept && (in_fmask != 8'h00),
                              wb_valid && (wb_fmask != 8'h00),
                              flush && out_valid && (out_fmask != 8'h00));
    end

    // Register file, flags and scoreboard state; writeback ignores stalls.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i]  <= '0;
                cnt[i] <= '0;
            end
            flags <= 8'h00;
            fcnt  <= '0;
        end else begin
            if (wb_valid && (wb_id != '0)) rf[wb_id] <= wb_data;
            if (wb_valid) flags <= flags_merged;
            for (int i = 0; i < NREGS; i++) cnt[i] <= cnt_nxt[i];
            fcnt <= fcnt_nxt;
        end
    end

    // EXE latch: flush empties it, mem_stall freezes it, otherwise load or bubble.
    always_ff @(posedge CLK) begin
        if (RST || flush || (!mem_stall && !accept)) begin
            out_valid    <= 1'b0;
            out_opcode   <= '0;
            out_wr_id    <= '0;
            out_fmask    <= '0;
            out_imm      <= '0;
            out_npc      <= '0;
            out_eoi      <= 1'b0;
            out_rd0_id   <= '0;
            out_rd1_id   <= '0;
            out_rd0_data <= '0;
            out_rd1_data <= '0;
            out_flags    <= '0;
        end else if (!mem_stall) begin
            out_valid    <= 1'b1;
            out_opcode   <= in_opcode;
            out_wr_id    <= in_wr_id;
            out_fmask    <= in_fmask;
            out_imm      <= in_imm;
            out_npc      <= in_npc;
            out_eoi      <= in_eoi;
            out_rd0_id   <= in_rd0_id;
            out_rd1_id   <= in_rd1_id;
            out_rd0_data <= rd0_data;
            out_rd1_data <= rd1_data;
            out_flags    <= flags_rd;
        end
    end

endmodule

// File: tb/tb_rf_read_stage_p.sv
// Directed bench for rf_read_stage_p: reset, issue, RAW stall, counter
// saturation, flush kill, mem_stall hold, id 0 and flags hazards.
module tb_rf_read_stage_p;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [5:0]  in_opcode = '0;
  logic [4:0]  in_rd0_id = '0;
  logic [4:0]  in_rd1_id = '0;
  logic [4:0]  in_wr_id = '0;
  logic [7:0]  in_fmask = '0;
  logic        in_rd_flags = 1'b0;
  logic [15:0] in_imm = '0;
  logic [15:0] in_npc = '0;
  logic        in_eoi = 1'b0;
  logic        flush = 1'b0;
  logic        mem_stall = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_id = '0;
  logic [15:0] wb_data = '0;
  logic [7:0]  wb_fmask = '0;
  logic [7:0]  wb_flags = '0;
  logic        stall_out, bubble, out_valid, out_eoi;
  logic [5:0]  out_opcode;
  logic [4:0]  out_wr_id, out_rd0_id, out_rd1_id;
  logic [7:0]  out_fmask, out_flags;
  logic [15:0] out_imm, out_npc, out_rd0_data, out_rd1_data;

  int checks = 0;
  int errors = 0;

  rf_read_stage_p dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_rd0_id(in_rd0_id), .in_rd1_id(in_rd1_id), .in_wr_id(in_wr_id),
    .in_fmask(in_fmask), .in_rd_flags(in_rd_flags), .in_imm(in_imm),
    .in_npc(in_npc), .in_eoi(in_eoi), .flush(flush), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
    .wb_fmask(wb_fmask), .wb_flags(wb_flags), .stall_out(stall_out),
    .bubble(bubble), .out_valid(out_valid), .out_opcode(out_opcode),
    .out_wr_id(out_wr_id), .out_fmask(out_fmask), .out_imm(out_imm),
    .out_npc(out_npc), .out_eoi(out_eoi), .out_rd0_id(out_rd0_id),
    .out_rd1_id(out_rd1_id), .out_rd0_data(out_rd0_data),
    .out_rd1_data(out_rd1_data), .out_flags(out_flags)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic uop(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                     input logic [4:0] wr, input logic [7:0] fm, input logic rf,
                     input logic [15:0] imm);
    in_valid = v; in_rd0_id = r0; in_rd1_id = r1; in_wr_id = wr;
    in_fmask = fm; in_rd_flags = rf; in_imm = imm;
  endtask

  task automatic wb(input logic v, input logic [4:0] id, input logic [15:0] d,
                    input logic [7:0] fm, input logic [7:0] fl);
    wb_valid = v; wb_id = id; wb_data = d; wb_fmask = fm; wb_flags = fl;
  endtask

  initial begin
    // reset
    step(); step();
    RST = 1'b0;
    settle();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_imm", 32'(out_imm), 32'h0);
    chk("rst_out_rd0", 32'(out_rd0_data), 32'h0);
    chk("rst_stall", 32'(stall_out), 32'h0);

    // preload r3, r4 and flags with idle-scoreboard writebacks
    wb(1'b1, 5'd3, 16'h0033, 8'h0F, 8'hA5); step();
    wb(1'b1, 5'd4, 16'h0044, 8'h00, 8'h00); step();
    wb(1'b0, 5'd0, 16'h0000, 8'h00, 8'h00);

    // basic issue: rd0=3 rd1=4 wr=5
    uop(1'b1, 5'd3, 5'd4, 5'd5, 8'h00, 1'b1, 16'h1234);
    in_opcode = 6'h2A; in_npc = 16'h0100; in_eoi = 1'b1;
    settle();
    chk("t1_stall", 32'(stall_out), 32'h0);
    chk("t1_bubble", 32'(bubble), 32'h0);
    step();
    chk("t1_out_valid", 32'(out_valid), 32'h1);
    chk("t1_out_imm", 32'(out_imm), 32'h1234);
    chk("t1_out_npc", 32'(out_npc), 32'h0100);
    chk("t1_out_opcode", 32'(out_opcode), 32'h2A);
    chk("t1_out_rd0", 32'(out_rd0_data), 32'h0033);
    chk("t1_out_rd1", 32'(out_rd1_data), 32'h0044);
    chk("t1_out_wr", 32'(out_wr_id), 32'h5);
    chk("t1_out_flags", 32'(out_flags), 32'h05);
    in_eoi = 1'b0; in_opcode = 6'h01;

    // RAW on r5: reader stalls until the writeback drains the counter
    uop(1'b1, 5'd5, 5'd0, 5'd0, 8'h00, 1'b0, 16'h0002);
    settle();
    chk("t2_stall_a", 32'(stall_out), 32'h1);
    chk("t2_bubble_a", 32'(bubble), 32'h1);
    step();
    chk("t2_bubble_latch", 32'(out_valid), 32'h0);
    chk("t2_stall_b", 32'(stall_out), 32'h1);
    step();
    wb(1'b1, 5'd5, 16'hBEEF, 8'h00, 8'h00);
    settle();
`ifdef RF_READ_FORWARD_EN
    chk("t2_stall_wb_fwd", 32'(stall_out), 32'h0);
    step();
    wb(1'b0, 5'd0, 16'h0000, 8'h00, 8'h00);
`else
    chk("t2_stall_wb", 32'(stall_out), 32'h1);
    step();
    wb(1'b0, 5'd0, 16'h0000, 8'h00, 8'h00);
    settle();
    chk("t2_stall_d", 32'(stall_out), 32'h0);
    step();
`endif
    chk("t2_out_valid", 32'(out_valid), 32'h1);
    chk("t2_out_rd0", 32'(out_rd0_data), 32'hBEEF);

    // three writers to r7 saturate the counter; the fourth waits for a writeback
    uop(1'b1, 5'd0, 5'd0, 5'd7, 8'h00, 1'b0, 16'h0007);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_stall_fill", 32'(stall_out), 32'h0);
      step();
    end
    chk("t3_stall_full", 32'(stall_out), 32'h1);
    chk("t3_bubble_full", 32'(bubble), 32'h1);
    step();
    chk("t3_latch_empty", 32'(out_valid), 32'h0);
    wb(1'b1, 5'd7, 16'h0777, 8'h00, 8'h00);
    settle();
    chk("t3_stall_wbcyc", 32'(stall_out), 32'h1);
    step();
    wb(1'b0, 5'd0, 16'h0000, 8'h00, 8'h00);
    settle();
    chk("t3_stall_free", 32'(stall_out), 32'h0);
    step();
    chk("t3_out_valid", 32'(out_valid), 32'h1);
    chk("t3_out_wr", 32'(out_wr_id), 32'h7);

    // flush kills latched writer of r9 and the current uop writing r10
    uop(1'b1, 5'd0, 5'd0, 5'd9, 8'h00, 1'b0, 16'h0009);
    step();
    chk("t4_latched", 32'(out_wr_id), 32'h9);
    uop(1'b1, 5'd0, 5'd0, 5'd10, 8'h00, 1'b0, 16'h5555);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_flushed_valid", 32'(out_valid), 32'h0);
    chk("t4_flushed_imm", 32'(out_imm), 32'h0);
    uop(1'b1, 5'd9, 5'd10, 5'd0, 8'h00, 1'b0, 16'h0A0A);
    settle();
    chk("t4_no_pending", 32'(stall_out), 32'h0);
    step();
    chk("t4_after_valid", 32'(out_valid), 32'h1);

    // mem_stall holds a live latch
    uop(1'b1, 5'd0, 5'd0, 5'd0, 8'h00, 1'b0, 16'hFFFF);
    mem_stall = 1'b1;
    settle();
    chk("t5_stall", 32'(stall_out), 32'h1);
    chk("t5_bubble", 32'(bubble), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t5_hold_valid", 32'(out_valid), 32'h1);
      chk("t5_hold_imm", 32'(out_imm), 32'h0A0A);
    end
    mem_stall = 1'b0;
    step();
    chk("t5_release_imm", 32'(out_imm), 32'hFFFF);

    // id 0 stays zero after a writeback to it
    uop(1'b0, 5'd0, 5'd0, 5'd0, 8'h00, 1'b0, 16'h0000);
    wb(1'b1, 5'd0, 16'hFFFF, 8'h00, 8'h00);
    step();
    wb(1'b0, 5'd0, 16'h0000, 8'h00, 8'h00);
    uop(1'b1, 5'd0, 5'd0, 5'd0, 8'h00, 1'b0, 16'h0000);
    settle();
    chk("t6_stall_id0", 32'(stall_out), 32'h0);
    step();
    chk("t6_rd0_zero", 32'(out_rd0_data), 32'h0);
    chk("t6_rd1_zero", 32'(out_rd1_data), 32'h0);

    // flags writer then flags reader
    uop(1'b1, 5'd0, 5'd0, 5'd0, 8'h01, 1'b0, 16'h00F1);
    step();
    uop(1'b1, 5'd0, 5'd0, 5'd0, 8'h00, 1'b1, 16'h00F2);
    settle();
    chk("t7_flag_stall", 32'(stall_out), 32'h1);
    step();
    wb(1'b1, 5'd0, 16'h0000, 8'hF0, 8'hA5);
    settle();
`ifdef RF_READ_FORWARD_EN
    chk("t7_flag_fwd", 32'(stall_out), 32'h0);
    step();
    wb(1'b0, 5'd0, 16'h0000, 8'h00, 8'h00);
`else
    chk("t7_flag_wbcyc", 32'(stall_out), 32'h1);
    step();
    wb(1'b0, 5'd0, 16'h0000, 8'h00, 8'h00);
    step();
`endif
    chk("t7_flags_valid", 32'(out_valid), 32'h1);
    chk("t7_flags_val", 32'(out_flags), 32'hA5);

    // reset during a hazard stall clears counters and latch
    uop(1'b1, 5'd7, 5'd0, 5'd0, 8'h00, 1'b0, 16'h0077);
    settle();
    chk("t8_pre_stall", 32'(stall_out), 32'h1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    settle();
    chk("t8_rst_valid", 32'(out_valid), 32'h0);
    chk("t8_rst_stall", 32'(stall_out), 32'h0);
    step();
    chk("t8_rst_rd0", 32'(out_rd0_data), 32'h0);
    uop(1'b0, 5'd0, 5'd0, 5'd0, 8'h00, 1'b0, 16'h0000);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
